// File: rtl/jk_sync_updown_counter.sv
// -----------------------------------------------------------------------------
// jk_sync_updown_counter
//
// Purpose:
//   Synchronous up/down binary counter built as an array of JK stages. Every
//   bit behaves like a JK flip-flop: J=K=1 toggles, J=K=0 holds, and a
//   parallel load is expressed as J=d, K=~d. The counter produces a
//   combinational terminal-count flag and a registered one-cycle wrap pulse.
//
// Optional feature (compile-time macro JK_CNT_MODULUS_EN):
//   When defined, the count range is 0..MODULUS-1. The toggle pattern is
//   overridden at the wrap points so every bit lands on the target value in a
//   single edge, and loads of d >= MODULUS are clamped to MODULUS-1.
//   When undefined, the full 0..2^WIDTH-1 range is used and MODULUS is ignored.
//
// Parameters:
//   WIDTH    number of counter bits / JK stages (2..16)
//   MODULUS  count modulus, only meaningful with JK_CNT_MODULUS_EN (2..2^WIDTH)
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (q = 0, wrap = 0)
//   en    in   count enable
//   up    in   direction, 1 = increment, 0 = decrement
//   load  in   synchronous parallel load, highest priority
//   d     in   parallel load value [WIDTH-1:0]
//   q     out  registered count [WIDTH-1:0]
//   tc    out  terminal count, combinational from q/en/up/load
//   wrap  out  registered pulse, high in the cycle q shows the wrapped value
// -----------------------------------------------------------------------------
module jk_sync_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

`ifdef JK_CNT_MODULUS_EN
   localparam logic [WIDTH-1:0] MaxCount    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   ModulusWide = (WIDTH + 1)'(MODULUS);
`else
   localparam logic [WIDTH-1:0] MaxCount    = '1;
`endif

   // Elaboration-time range guard: an illegal parameter set shows up as the
   // marker scope g_illegalParams in the elaborated hierarchy.
   if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_illegalParams
   end

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;

   logic [WIDTH-1:0] w_onesBelow;
   logic [WIDTH-1:0] w_zerosBelow;
   logic [WIDTH-1:0] w_toggle;
   logic [WIDTH-1:0] w_loadVal;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic [WIDTH-1:0] w_next;
   logic             w_atMax;
   logic             w_atMin;
   logic             w_tc;

   assign w_atMax = (r_q == MaxCount);
   assign w_atMin = (r_q == '0);

   // Terminal count only when an enabled, non-load edge would wrap.
   assign w_tc = en & ~load & ((up & w_atMax) | (~up & w_atMin));

   // Ripple-style prefix of "all lower bits are ones / zeros" gives each
   // stage its toggle condition: carry for counting up, borrow for down.
   always_comb begin
      w_onesBelow     = '0;
      w_zerosBelow    = '0;
      w_onesBelow[0]  = 1'b1;
      w_zerosBelow[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         w_onesBelow[i]  = w_onesBelow[i-1]  & r_q[i-1];
         w_zerosBelow[i] = w_zerosBelow[i-1] & ~r_q[i-1];
      end
   end

   // Toggle vector feeding J=K of each stage. With a truncated modulus the
   // natural carry/borrow pattern does not reach 0 / MODULUS-1, so the wrap
   // points toggle exactly the bits that differ from the target value.
   always_comb begin
      w_toggle = '0;
      if (en) begin
         w_toggle = up ? w_onesBelow : w_zerosBelow;
`ifdef JK_CNT_MODULUS_EN
         if (up && w_atMax) begin
            w_toggle = r_q;
         end else if (!up && w_atMin) begin
            w_toggle = MaxCount;
         end
`endif
      end
   end

   // Load value, clamped into the legal range when a modulus is in force.
   always_comb begin
      w_loadVal = d;
`ifdef JK_CNT_MODULUS_EN
      if ({1'b0, d} >= ModulusWide) begin
         w_loadVal = MaxCount;
      end
`endif
   end

   // JK inputs per stage: load forces J=d/K=~d, otherwise J=K=toggle.
   // The characteristic equation Q+ = J&~Q | ~K&Q then gives the next state.
   always_comb begin
      w_j = w_toggle;
      w_k = w_toggle;
      if (load) begin
         w_j = w_loadVal;
         w_k = ~w_loadVal;
      end
      w_next = (w_j & ~r_q) | (~w_k & r_q);
   end

   // State registers; wrap simply records that the edge just taken was a
   // terminal-count edge, so it is high while q shows the wrapped value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_q    <= w_next;
         r_wrap <= w_tc;
      end
   end

   assign q    = r_q;
   assign tc   = w_tc;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_sync_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_sync_updown_counter
//
// Self-checking bench for jk_sync_updown_counter. A driver applies directed and
// randomized stimulus on the falling edge, computes the expected response with
// a modular-arithmetic reference model and queues it. A separate monitor pops
// each queued entry, checking tc before the rising edge and q/wrap after it.
// Build with JK_CNT_MODULUS_EN defined to exercise the modulus variant.
// -----------------------------------------------------------------------------
module tb_jk_sync_updown_counter;

   localparam int W   = 4;
   localparam int MOD = 10;

`ifdef JK_CNT_MODULUS_EN
   localparam int Range = MOD;
`else
   localparam int Range = 1 << W;
`endif
   localparam int MaxV = Range - 1;

   typedef struct {
      logic         tc;
      logic [W-1:0] q;
      logic         wrap;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         tc;
   logic         wrap;

   exp_t expQ[$];
   int   model;
   int   testsRun;
   int   testsFailed;

   jk_sync_updown_counter #(
      .WIDTH   (W),
      .MODULUS (MOD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
      .load (load),
      .d    (d),
      .q    (q),
      .tc   (tc),
      .wrap (wrap)
   );

   // 20-unit clock period; leaves room for the between-edge reset pulses.
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (model count %0d)", name, actual, expected, model);
      end
   endtask

   // Drive one cycle of inputs and queue what the counter must show.
   // The model works on the integer count with plain modular arithmetic.
   task automatic applyStimulus(input logic iEn, input logic iUp, input logic iLoad, input logic [W-1:0] iD);
      exp_t e;
      int   nxt;
      @(negedge clk);
      en   = iEn;
      up   = iUp;
      load = iLoad;
      d    = iD;
      e.tc = iEn && !iLoad && ((iUp && model == MaxV) || (!iUp && model == 0));
      if (iLoad) begin
         nxt = (int'(iD) > MaxV) ? MaxV : int'(iD);
      end else if (iEn) begin
         nxt = iUp ? (model + 1) % Range : (model + Range - 1) % Range;
      end else begin
         nxt = model;
      end
      e.q    = W'(nxt);
      e.wrap = e.tc;
      expQ.push_back(e);
      model = nxt;
   endtask

   // Asynchronous reset pulse placed between edges, after the monitor has
   // sampled the previous edge and well before the next falling edge.
   task automatic pulseReset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("asyncResetQ", int'(q), 0);
      checkOutput("asyncResetWrap", int'(wrap), 0);
      #1;
      rst   = 1'b0;
      model = 0;
   endtask

   // Monitor: tc is checked after inputs settle, q/wrap after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ[0];
            checkOutput("tc", int'(tc), int'(e.tc));
            @(posedge clk);
            #1;
            checkOutput("q", int'(q), int'(e.q));
            checkOutput("wrap", int'(wrap), int'(e.wrap));
            void'(expQ.pop_front());
         end
      end
   end

   // Driver: directed scenarios first, then a randomized soak.
   initial begin
      int waitCycles;
      testsRun    = 0;
      testsFailed = 0;
      model       = 0;
      rst  = 1'b1;
      en   = 1'($urandom);
      up   = 1'($urandom);
      load = 1'($urandom);
      d    = W'($urandom);
      #1;
      checkOutput("resetQ", int'(q), 0);
      checkOutput("resetWrap", int'(wrap), 0);
      @(posedge clk);
      #5;
      rst = 1'b0;

      // Idle after release: q stays 0 until an enabled edge.
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);

      // Up count through the wrap point and one step beyond.
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);

      // Down wrap from a loaded 1.
      applyStimulus(1'b0, 1'b0, 1'b1, W'(1));
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);

      // Load beats count; load at the terminal value kills tc and wrap.
      applyStimulus(1'b0, 1'b1, 1'b1, W'(6));
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 1'b1, W'(4'hA));
      applyStimulus(1'b0, 1'b1, 1'b1, W'(MaxV));
      applyStimulus(1'b1, 1'b1, 1'b1, W'(3));
      applyStimulus(1'b1, 1'b1, 1'b0, '0);

      // Hold for five edges, then reset mid-count.
      applyStimulus(1'b0, 1'b1, 1'b1, W'(9));
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'($urandom), 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b1, W'(11));
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      pulseReset();

      // Down from zero wraps to the maximum; load above range.
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 1'b1, W'(13));
      applyStimulus(1'b1, 1'b1, 1'b1, W'(15));
      applyStimulus(1'b1, 1'b0, 1'b0, '0);

      // Randomized soak with occasional loads, direction flips and resets.
      for (int n = 0; n < 400; n++) begin
         if (n % 97 == 50) pulseReset();
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) == 0), W'($urandom));
      end

      // Drain the scoreboard within a fixed cycle budget.
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      #3;
      checkOutput("scoreboardDrained", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
